// File: rtl/song_reader_pkg.sv
// Shared types and constants for the song reader, plus the song ROM image.
// Optional feature macro: SONG_READER_REST_SKIP_EN (skip rest entries, note==0).
package song_reader_pkg;

  localparam int unsigned NOTE_W = 6;
  localparam int unsigned DUR_W  = 6;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned SONG_W = 2;
  localparam int unsigned ADDR_W = SONG_W + IDX_W;
  localparam int unsigned DATA_W = NOTE_W + DUR_W;

  // A zero duration marks the end of a song.
  localparam logic [DUR_W-1:0] END_DUR = '0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCheck,
    StWait,
    StDone,
    StEnd
  } state_e;

  // Memory image of the 128x12 song ROM: {note[11:6], duration[5:0]}.
  // Song 0: short tune with a rest at entry 2, terminated at entry 4.
  // Song 1: three notes, terminated at entry 3.
  // Song 2: all 32 entries are notes (note = entry+1, duration cycles 1..4).
  // Song 3: opens with a rest, terminated at entry 3.
  function automatic logic [DATA_W-1:0] rom_image(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] d;
    d = '0;
    case (addr[6:5])
      2'd0: begin
        case (addr[4:0])
          5'd0:    d = {6'd12, 6'd4};
          5'd1:    d = {6'd14, 6'd2};
          5'd2:    d = {6'd0,  6'd3};
          5'd3:    d = {6'd16, 6'd1};
          default: d = '0;
        endcase
      end
      2'd1: begin
        case (addr[4:0])
          5'd0:    d = {6'd20, 6'd1};
          5'd1:    d = {6'd21, 6'd2};
          5'd2:    d = {6'd22, 6'd3};
          5'd3:    d = {6'd5,  6'd0};
          default: d = '0;
        endcase
      end
      2'd2: begin
        d = {({1'b0, addr[4:0]} + 6'd1), ({4'd0, addr[1:0]} + 6'd1)};
      end
      default: begin
        case (addr[4:0])
          5'd0:    d = {6'd0,  6'd5};
          5'd1:    d = {6'd33, 6'd6};
          5'd2:    d = {6'd34, 6'd1};
          default: d = '0;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/song_rom.sv
// 128x12 song ROM with a one-cycle registered read.
module song_rom
  import song_reader_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout
);

  // Registered read of the ROM image.
  always_ff @(posedge clk) begin
    dout <= rom_image(addr);
  end

endmodule

// File: rtl/song_reader.sv
// Song reader: walks one song of the ROM, issuing note/duration pairs to a note
// player and waiting for note_done between notes.
// Optional feature macro: SONG_READER_REST_SKIP_EN -- rest entries (note==0 with a
// non-zero duration) are skipped instead of being issued.
module song_reader
  import song_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              play,
  input  logic              reset_player,
  input  logic [SONG_W-1:0] song,
  input  logic              note_done,
  output logic [NOTE_W-1:0] note,
  output logic [DUR_W-1:0]  duration,
  output logic              new_note,
  output logic              song_done
);

  state_e            state_q;
  state_e            adv_state;
  logic [IDX_W-1:0]  idx_q;
  logic [SONG_W-1:0] song_q;
  logic [DATA_W-1:0] rom_dout;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;
  logic              last_note;
  logic              rest_skip;

  song_rom u_song_rom (
    .clk  (clk),
    .addr ({song_q, idx_q}),
    .dout (rom_dout)
  );

  assign rom_note  = rom_dout[DATA_W-1:DUR_W];
  assign rom_dur   = rom_dout[DUR_W-1:0];
  assign last_note = (idx_q == '1);

`ifdef SONG_READER_REST_SKIP_EN
  assign rest_skip = (rom_note == '0);
`else
  assign rest_skip = 1'b0;
`endif

  // Where a finished (or skipped) entry leads: the last entry always ends the song.
  always_comb begin
    adv_state = StIdle;
    if (last_note) begin
      adv_state = StDone;
    end else if (play) begin
      adv_state = StFetch;
    end
  end

  // Main sequencer with registered outputs; reset_player overrides everything else.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      song_q    <= '0;
      note      <= '0;
      duration  <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else if (reset_player) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      song_q    <= song;
      note      <= '0;
      duration  <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else begin
      new_note  <= 1'b0;
      song_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (play) begin
            state_q <= StFetch;
          end
        end
        // ROM address is driven from idx_q; data is registered this edge.
        StFetch: state_q <= StCheck;
        StCheck: begin
          if (rom_dur == END_DUR) begin
            state_q <= StDone;
          end else if (rest_skip) begin
            state_q <= adv_state;
            if (!last_note) begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            note     <= rom_note;
            duration <= rom_dur;
            new_note <= 1'b1;
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (note_done) begin
            state_q <= adv_state;
            if (!last_note) begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StDone: begin
          song_done <= 1'b1;
          state_q   <= StEnd;
        end
        StEnd:   state_q <= StEnd;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
